// File: rtl/pipelined_cla.sv
// Pipelined carry-lookahead add/subtract: one BLK-bit lookahead block per stage, carry handed
// between stages in registers, valid/ready wrapped. Define PCLA_SAT_EN for signed saturation.
module pipelined_cla #(
  parameter int WIDTH = 32,
  parameter int BLK   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int NBLK = WIDTH / BLK;

  typedef struct packed {
    logic [BLK-1:0] s;
    logic           co;
    logic           cm;
  } blk_res_t;

  // Prefix generate/propagate over the block; every carry is G[i:0] | P[i:0] & cin.
  function automatic blk_res_t blk_add(input logic [BLK-1:0] x, input logic [BLK-1:0] y,
                                       input logic ci);
    logic [BLK-1:0] p;
    logic [BLK-1:0] g;
    logic [BLK:0]   c;
    logic           gp;
    logic           pp;
    blk_res_t       r;
    p    = x ^ y;
    g    = x & y;
    gp   = 1'b0;
    pp   = 1'b1;
    c[0] = ci;
    for (int i = 0; i < BLK; i++) begin
      gp     = g[i] | (p[i] & gp);
      pp     = pp & p[i];
      c[i+1] = gp | (pp & ci);
    end
    r.s  = p ^ c[BLK-1:0];
    r.co = c[BLK];
    r.cm = c[BLK-1];
    return r;
  endfunction

  // Stage registers; a_q/b_q hold the skewed (op-adjusted) operands, sum_q the finished slices.
  logic [NBLK-1:0]  vld_q, vld_d;
  logic [NBLK-1:0]  cy_q,  cy_d;
  logic [NBLK-1:0]  z_q,   z_d;
  logic [WIDTH-1:0] sum_q [NBLK];
  logic [WIDTH-1:0] sum_d [NBLK];
  logic [WIDTH-1:0] a_q   [NBLK];
  logic [WIDTH-1:0] a_d   [NBLK];
  logic [WIDTH-1:0] b_q   [NBLK];
  logic [WIDTH-1:0] b_d   [NBLK];
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] src_s [NBLK];
  logic [NBLK-1:0]  src_z;
  logic [NBLK-1:0]  src_c;
  logic             msb_c;
  logic             advance;

  assign out_valid = vld_q[NBLK-1];
  assign advance   = !out_valid | out_ready;
  assign in_ready  = advance & !rst;

  always_comb begin
    blk_res_t res;
    // NOTE: every combinational output gets a value on every path before any conditional
    // override, so no latch can be inferred.
    res        = '0;
    msb_c      = 1'b0;
    a_d[0]     = a;
    b_d[0]     = op ? ~b : b;
    src_s[0]   = '0;
    src_z[0]   = 1'b1;
    src_c[0]   = op | c_in;
    vld_d[0]   = in_valid;
    for (int k = 1; k < NBLK; k++) begin
      a_d[k]   = a_q[k-1];
      b_d[k]   = b_q[k-1];
      src_s[k] = sum_q[k-1];
      src_z[k] = z_q[k-1];
      src_c[k] = cy_q[k-1];
      vld_d[k] = vld_q[k-1];
    end
    for (int k = 0; k < NBLK; k++) begin
      res                     = blk_add(a_d[k][k*BLK +: BLK], b_d[k][k*BLK +: BLK], src_c[k]);
      sum_d[k]                = src_s[k];
      sum_d[k][k*BLK +: BLK]  = res.s;
      cy_d[k]                 = res.co;
      z_d[k]                  = src_z[k] & (res.s == '0);
      msb_c                   = res.cm;
    end
    ovf_d = cy_d[NBLK-1] ^ msb_c;
`ifdef PCLA_SAT_EN
    // Overflow implies a and op-adjusted b share a sign, so a's MSB gives the direction.
    if (ovf_d) begin
      sum_d[NBLK-1] = a_d[NBLK-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                           : {1'b0, {(WIDTH-1){1'b1}}};
      z_d[NBLK-1]   = 1'b0;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples the
  // previous stage's old value on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      cy_q  <= '0;
      z_q   <= '0;
      ovf_q <= 1'b0;
      // NOTE: the stage data arrays are flops, not RAM, so clearing them on reset is cheap
      // and keeps the output bus at zero until the first result arrives.
      for (int k = 0; k < NBLK; k++) begin
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else if (advance) begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      z_q   <= z_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < NBLK; k++) begin
        sum_q[k] <= sum_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
      end
    end
  end

  assign sum   = sum_q[NBLK-1];
  assign c_out = cy_q[NBLK-1];
  assign zero  = z_q[NBLK-1];
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_pipelined_cla.sv
// Self-checking bench for pipelined_cla: directed 32/8 sequence plus a 8/8, 16/4, 64/16 sweep,
// each scored against a behavioural a+/-b model. Honours PCLA_SAT_EN when defined.
module tb_pipelined_cla;

`ifdef PCLA_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [63:0] sum;
    logic        co;
    logic        ov;
    logic        z;
    int          edge_n;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, c_in, op, out_valid, out_ready, c_out, ovf, zero;
  logic [31:0] a, b, sum;
  logic        sw_valid, sw_cin, sw_op;
  logic [63:0] sw_a, sw_b;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  pipelined_cla #(.WIDTH(32), .BLK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .c_in(c_in), .op(op), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .c_out(c_out), .ovf(ovf), .zero(zero)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] x, input logic [63:0] y, input logic ci,
                                 input logic o, input int w);
    exp_t        e;
    logic [63:0] mask, xx, yy, s;
    logic [64:0] full;
    mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    xx     = x & mask;
    yy     = (o ? ~y : y) & mask;
    full   = {1'b0, xx} + {1'b0, yy} + {64'd0, (o ? 1'b1 : ci)};
    s      = full[63:0] & mask;
    e.co   = full[w];
    e.ov   = (xx[w-1] == yy[w-1]) && (s[w-1] != xx[w-1]);
    if (SAT && e.ov) s = xx[w-1] ? (64'd1 << (w - 1)) : (mask >> 1);
    e.sum  = s;
    e.z    = (s == 64'd0);
    e.edge_n = 0;
    return e;
  endfunction

  // Main scoreboard: push on accept, compare the head every cycle out_valid is up.
  always @(negedge clk) begin
    exp_t e;
    if (in_valid && in_ready) begin
      e = model({32'd0, a}, {32'd0, b}, c_in, op, 32);
      e.edge_n = cyc + 1;
      sb.push_back(e);
    end
    if (out_valid) begin
      if (sb.size() == 0) check("main spurious out_valid", {63'd0, out_valid}, 64'd0);
      else begin
        e = sb[0];
        check("main sum",   {32'd0, sum},   e.sum);
        check("main c_out", {63'd0, c_out}, {63'd0, e.co});
        check("main ovf",   {63'd0, ovf},   {63'd0, e.ov});
        check("main zero",  {63'd0, zero},  {63'd0, e.z});
        if (!out_ready) check("main stall in_ready", {63'd0, in_ready}, 64'd0);
        else void'(sb.pop_front());
      end
    end
  end

  localparam int SW_W[3] = '{8, 16, 64};
  localparam int SW_B[3] = '{8, 4, 16};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sw
    localparam int W = SW_W[gi];
    localparam int B = SW_B[gi];
    logic [W-1:0] s;
    logic         rdy, vld, co, ov, z;
    exp_t         q[$];

    pipelined_cla #(.WIDTH(W), .BLK(B)) u_dut (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy), .a(sw_a[W-1:0]),
      .b(sw_b[W-1:0]), .c_in(sw_cin), .op(sw_op), .out_valid(vld), .out_ready(1'b1),
      .sum(s), .c_out(co), .ovf(ov), .zero(z)
    );

    always @(negedge clk) begin
      exp_t e;
      if (sw_valid && rdy) begin
        e = model(sw_a, sw_b, sw_cin, sw_op, W);
        e.edge_n = cyc + 1;
        q.push_back(e);
      end
      if (vld) begin
        if (q.size() == 0) check($sformatf("w%0d spurious", W), {63'd0, vld}, 64'd0);
        else begin
          e = q.pop_front();
          check($sformatf("w%0d sum", W),     64'(s),         e.sum);
          check($sformatf("w%0d c_out", W),   {63'd0, co},    {63'd0, e.co});
          check($sformatf("w%0d ovf", W),     {63'd0, ov},    {63'd0, e.ov});
          check($sformatf("w%0d zero", W),    {63'd0, z},     {63'd0, e.z});
          check($sformatf("w%0d latency", W), 64'(cyc - e.edge_n + 1), 64'(W / B));
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc,
                      input logic to);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    a = ta; b = tb_v; c_in = tc; op = to; in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    check("send accepted", {63'd0, acc}, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int t_acc, input logic [31:0] es,
                            input logic eco, input logic eov, input logic ez);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    check({tag, " out_valid"}, {63'd0, seen}, 64'd1);
    check({tag, " latency"}, 64'(cyc - t_acc + 1), 64'd4);
    check({tag, " sum"},   {32'd0, sum},   {32'd0, es});
    check({tag, " c_out"}, {63'd0, c_out}, {63'd0, eco});
    check({tag, " ovf"},   {63'd0, ovf},   {63'd0, eov});
    check({tag, " zero"},  {63'd0, zero},  {63'd0, ez});
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; op = 1'b0; out_ready = 1'b1;
    sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_op = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", {63'd0, out_valid}, 64'd0);
    check("reset sum",       {32'd0, sum},       64'd0);
    check("reset flags",     {61'd0, c_out, ovf, zero}, 64'd0);
    check("reset in_ready",  {63'd0, in_ready},  64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0); t0 = cyc;
    expect_out("add ff+1", t0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0); t0 = cyc;
    expect_out("carry chain", t0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    send(32'd5, 32'd7, 1'b1, 1'b1); t0 = cyc;
    expect_out("sub 5-7", t0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0); t0 = cyc;
    expect_out("pos ovf", t0, SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1); t0 = cyc;
    expect_out("neg ovf", t0, SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

    // Back-to-back stream, then a 3-cycle stall with a beat waiting at the input.
    t0 = cyc;
    for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom), 1'($urandom));
    check("stream one beat per clock", 64'(cyc - t0), 64'd8);
    a = 32'h1234_5678; b = 32'h0FED_CBA9; c_in = 1'b1; op = 1'b0; in_valid = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall in_ready",  {63'd0, in_ready},  64'd0);
      check("stall out_valid", {63'd0, out_valid}, 64'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'($urandom), 1'($urandom));
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("stream drained", 64'(sb.size()), 64'd0);

    // Reset with three beats in flight: nothing may emerge afterwards.
    for (int i = 0; i < 3; i++) send($urandom | 32'h1, $urandom, 1'b0, 1'b0);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("rst in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst out_valid", {63'd0, out_valid}, 64'd0);
    check("rst sum",       {32'd0, sum},       64'd0);
    check("rst in_ready held", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post-rst no stale", {63'd0, out_valid}, 64'd0);
      @(posedge clk); #1;
    end

    // Parameter sweep: all three instances fed one beat per clock.
    sw_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 0) begin
        sw_a = '1; sw_b = '0; sw_cin = 1'b1; sw_op = 1'b0;
      end else if (i == 1) begin
        sw_a = '0; sw_b = 64'd1; sw_cin = 1'b0; sw_op = 1'b1;
      end else begin
        sw_a = {$urandom, $urandom}; sw_b = {$urandom, $urandom};
        sw_cin = 1'($urandom); sw_op = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    sw_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("w8 drained",  64'(g_sw[0].q.size()), 64'd0);
    check("w16 drained", 64'(g_sw[1].q.size()), 64'd0);
    check("w64 drained", 64'(g_sw[2].q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
